// File: rtl/iob_sync_pkg.sv
// Shared types and constants for the synchronizer stable-value qualifier.
package iob_sync_pkg;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_e;

  localparam int GLITCH_CNT_W = 16;

endpackage

// File: rtl/iob_sync_stable_qual_if.sv
// Bus bundle between the upstream synchronizer/consumer and the stable qualifier.
// Optional glitch counter signals exist only with IOB_SYNC_STABLE_QUAL_GLITCH_CNT_EN.
interface iob_sync_stable_qual_if
  import iob_sync_pkg::*;
#(
  parameter int DATA_W = 32
);

  logic [DATA_W-1:0] rst_val;
  logic              en;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              update_o;
  logic              settling_o;
`ifdef IOB_SYNC_STABLE_QUAL_GLITCH_CNT_EN
  logic                    glitch_clr;
  logic [GLITCH_CNT_W-1:0] glitch_cnt_o;
`endif

  modport master (
    output rst_val,
    output en,
    output data_in,
`ifdef IOB_SYNC_STABLE_QUAL_GLITCH_CNT_EN
    output glitch_clr,
    input  glitch_cnt_o,
`endif
    input  data_out,
    input  update_o,
    input  settling_o
  );

  modport slave (
    input  rst_val,
    input  en,
    input  data_in,
`ifdef IOB_SYNC_STABLE_QUAL_GLITCH_CNT_EN
    input  glitch_clr,
    output glitch_cnt_o,
`endif
    output data_out,
    output update_o,
    output settling_o
  );

endinterface

// File: rtl/iob_sync_stable_qual.sv
// Accepts a synchronized bus value only after STABLE_CYC identical enabled samples.
// Optional saturating glitch counter under IOB_SYNC_STABLE_QUAL_GLITCH_CNT_EN.
module iob_sync_stable_qual
  import iob_sync_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int STABLE_CYC = 3
) (
  input logic                   clk,
  input logic                   rst,
  iob_sync_stable_qual_if.slave bus
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [DATA_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_e            state_q, state_d;
  logic              update_q, update_d;
`ifdef IOB_SYNC_STABLE_QUAL_GLITCH_CNT_EN
  logic                    glitch_evt;
  logic [GLITCH_CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;
`endif

  always_comb begin
    data_out_d = data_out_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    update_d   = 1'b0;
`ifdef IOB_SYNC_STABLE_QUAL_GLITCH_CNT_EN
    glitch_evt = 1'b0;
`endif
    if (bus.en) begin
      unique case (state_q)
        ST_STABLE: begin
          if (bus.data_in != data_out_q) begin
            if (STABLE_CYC == 1) begin
              data_out_d = bus.data_in;
              update_d   = 1'b1;
            end else begin
              cand_d  = bus.data_in;
              cnt_d   = CNT_ONE;
              state_d = ST_SETTLING;
            end
          end
        end
        ST_SETTLING: begin
          if (bus.data_in == cand_q) begin
            if (cnt_q == CNT_LAST) begin
              data_out_d = cand_q;
              update_d   = 1'b1;
              cnt_d      = '0;
              state_d    = ST_STABLE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if (bus.data_in == data_out_q) begin
            // Bus fell back to the accepted value: drop the candidate quietly.
            cnt_d   = '0;
            state_d = ST_STABLE;
`ifdef IOB_SYNC_STABLE_QUAL_GLITCH_CNT_EN
            glitch_evt = 1'b1;
`endif
          end else begin
            cand_d = bus.data_in;
            cnt_d  = CNT_ONE;
`ifdef IOB_SYNC_STABLE_QUAL_GLITCH_CNT_EN
            glitch_evt = 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IOB_SYNC_STABLE_QUAL_GLITCH_CNT_EN
  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (bus.glitch_clr) begin
      glitch_cnt_d = '0;
    end else if (glitch_evt && (glitch_cnt_q != '1)) begin
      glitch_cnt_d = glitch_cnt_q + GLITCH_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_cnt_q <= '0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign bus.glitch_cnt_o = glitch_cnt_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q <= bus.rst_val;
      cand_q     <= bus.rst_val;
      cnt_q      <= '0;
      state_q    <= ST_STABLE;
      update_q   <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      update_q   <= update_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.update_o   = update_q;
  assign bus.settling_o = (state_q == ST_SETTLING);

endmodule

// File: tb/tb_iob_sync_stable_qual.sv
// Self-checking bench for iob_sync_stable_qual: directed scenarios plus random runs
// compared against a run-length reference model.
module tb_iob_sync_stable_qual;

  localparam int DATA_W     = 32;
  localparam int STABLE_CYC = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: value on the output, plus the current run of identical enabled samples.
  logic [DATA_W-1:0] m_out;
  logic [DATA_W-1:0] m_run_val;
  int                m_run_len;
  logic              m_upd;
  int                m_glitch;

  iob_sync_stable_qual_if #(.DATA_W(DATA_W)) bus ();

  iob_sync_stable_qual #(
    .DATA_W    (DATA_W),
    .STABLE_CYC(STABLE_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_settling();
    return (STABLE_CYC > 1) && (m_run_val != m_out);
  endfunction

  task automatic model_reset(input logic [DATA_W-1:0] rv);
    m_out     = rv;
    m_run_val = rv;
    m_run_len = 0;
    m_upd     = 1'b0;
    m_glitch  = 0;
  endtask

  task automatic model_edge(input logic e, input logic [DATA_W-1:0] d, input logic clr);
    logic was_settling;
    logic [DATA_W-1:0] prev_run;
    was_settling = model_settling();
    prev_run     = m_run_val;
    m_upd        = 1'b0;
    if (e) begin
      if (d == m_run_val) begin
        if (m_run_len < 1000) m_run_len++;
      end else begin
        m_run_val = d;
        m_run_len = 1;
      end
      if (d != m_out && m_run_len >= STABLE_CYC) begin
        m_out = d;
        m_upd = 1'b1;
      end
    end
    if (clr) m_glitch = 0;
    else if (e && was_settling && d != prev_run && m_glitch < 16'hFFFF) m_glitch++;
  endtask

  task automatic check_output(input string tag);
    check({tag, ".data_out"}, bus.data_out, m_out);
    check({tag, ".update_o"}, {31'b0, bus.update_o}, {31'b0, m_upd});
    check({tag, ".settling_o"}, {31'b0, bus.settling_o}, {31'b0, model_settling()});
`ifdef IOB_SYNC_STABLE_QUAL_GLITCH_CNT_EN
    check({tag, ".glitch_cnt"}, {16'b0, bus.glitch_cnt_o}, m_glitch);
`endif
  endtask

  task automatic apply_stimulus(input string tag, input logic e, input logic [DATA_W-1:0] d,
                                input logic clr = 1'b0);
    bus.en      = e;
    bus.data_in = d;
`ifdef IOB_SYNC_STABLE_QUAL_GLITCH_CNT_EN
    bus.glitch_clr = clr;
`endif
    @(posedge clk);
    model_edge(e, d, clr);
    #1;
    check_output(tag);
`ifdef IOB_SYNC_STABLE_QUAL_GLITCH_CNT_EN
    bus.glitch_clr = 1'b0;
`endif
  endtask

  task automatic do_reset(input logic [DATA_W-1:0] rv);
    bus.rst_val = rv;
    bus.data_in = rv;
    bus.en      = 1'b0;
    rst         = 1'b1;
    model_reset(rv);
    #1;
    check_output("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    int hold;
    bus.rst_val = '0;
    bus.en      = 1'b0;
    bus.data_in = '0;
`ifdef IOB_SYNC_STABLE_QUAL_GLITCH_CNT_EN
    bus.glitch_clr = 1'b0;
`endif

    // Reset value held on the input: nothing should move.
    do_reset(32'hA5A5A5A5);
    for (int i = 0; i < 10; i++) apply_stimulus("hold_rstval", 1'b1, 32'hA5A5A5A5);
    check("hold_rstval.final", bus.data_out, 32'hA5A5A5A5);

    // Clean change accepted after three samples.
    do_reset('0);
    apply_stimulus("clean_e0", 1'b1, 32'h12345678);
    check("clean_e0.settling", {31'b0, bus.settling_o}, 32'd1);
    apply_stimulus("clean_e1", 1'b1, 32'h12345678);
    check("clean_e1.data_out", bus.data_out, 32'h0);
    apply_stimulus("clean_e2", 1'b1, 32'h12345678);
    check("clean_e2.data_out", bus.data_out, 32'h12345678);
    check("clean_e2.update", {31'b0, bus.update_o}, 32'd1);
    apply_stimulus("clean_e3", 1'b1, 32'h12345678);
    check("clean_e3.update", {31'b0, bus.update_o}, 32'd0);

    // Single-cycle glitch is discarded.
    do_reset('0);
    apply_stimulus("glitch_0", 1'b1, 32'h0000FF00);
    for (int i = 0; i < 4; i++) apply_stimulus("glitch_back", 1'b1, 32'h0);
    check("glitch.data_out", bus.data_out, 32'h0);
`ifdef IOB_SYNC_STABLE_QUAL_GLITCH_CNT_EN
    check("glitch.cnt", {16'b0, bus.glitch_cnt_o}, 32'd1);
`endif

    // Skewed intermediate value never reaches the output.
    apply_stimulus("skew_0f", 1'b1, 32'h0F);
    apply_stimulus("skew_ff0", 1'b1, 32'hFF);
    apply_stimulus("skew_ff1", 1'b1, 32'hFF);
    check("skew_ff1.data_out", bus.data_out, 32'h0);
    apply_stimulus("skew_ff2", 1'b1, 32'hFF);
    check("skew_ff2.data_out", bus.data_out, 32'hFF);
    check("skew_ff2.update", {31'b0, bus.update_o}, 32'd1);
    apply_stimulus("skew_ff3", 1'b1, 32'hFF);

    // Enable gaps neither count nor break the run.
    apply_stimulus("en_1a", 1'b1, 32'h5);
    apply_stimulus("en_0a", 1'b0, 32'h5);
    apply_stimulus("en_1b", 1'b1, 32'h5);
    apply_stimulus("en_0b", 1'b0, 32'h5);
    check("en_0b.data_out", bus.data_out, 32'hFF);
    check("en_0b.update", {31'b0, bus.update_o}, 32'd0);
    apply_stimulus("en_1c", 1'b1, 32'h5);
    check("en_1c.data_out", bus.data_out, 32'h5);
    apply_stimulus("en_0c", 1'b0, 32'h5);
    check("en_0c.update", {31'b0, bus.update_o}, 32'd0);

    // Asynchronous reset in the middle of settling.
    apply_stimulus("async_pre", 1'b1, 32'hAB);
    check("async_pre.settling", {31'b0, bus.settling_o}, 32'd1);
    #2;
    bus.rst_val = 32'h77;
    rst         = 1'b1;
    model_reset(32'h77);
    #1;
    check("async.data_out", bus.data_out, 32'h77);
    check("async.settling", {31'b0, bus.settling_o}, 32'd0);
    check("async.update", {31'b0, bus.update_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus("async_post", 1'b1, 32'h77);

    // Randomized runs: values drawn from a small pool so runs and glitches are common.
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 4))
        0:       v = 32'h0;
        1:       v = 32'h1;
        2:       v = 32'hFF;
        3:       v = m_out;
        default: v = $urandom();
      endcase
      hold = $urandom_range(1, 5);
      for (int k = 0; k < hold; k++) begin
        apply_stimulus("random", ($urandom_range(0, 3) != 0), v,
                       ($urandom_range(0, 63) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    mismatched++;
    $display("[TB] FAIL timeout observed=running required=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/iob_sync_stable_qual.md
Name: iob_sync_stable_qual

Overview:
- Sits directly downstream of the slow-to-fast 2-flop synchronizer, in the fast clock domain.
- A multi-bit bus crossing domains can show mixed old/new bits for a cycle. This block accepts a new value only after it has held identical for STABLE_CYC consecutive samples.
- Presents the qualified value on data_out and pulses update_o on every accepted change.

Parameters:
- DATA_W, 32, width of data bus.
- STABLE_CYC, 3, consecutive identical samples required to accept a value; legal range 1..255.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- rst_val  input  DATA_W  value loaded into data_out/cand on reset.
- en  input  1  sample enable; when 0 all state freezes.
- data_in  input  DATA_W  synchronized bus from upstream synchronizer.
- data_out  output  DATA_W  qualified value, registered.
- update_o  output  1  one-cycle pulse, high in the cycle after data_out changes.
- settling_o  output  1  high while a candidate value is being qualified.

Behaviour:
- Registers:
  - data_out, cand (DATA_W).
  - cnt (CNT_W).
  - state: STABLE or SETTLING.
  - update_o.
- Reset (async): data_out=cand=rst_val, cnt=0, state=STABLE, update_o=0, settling_o=0.
- settling_o = (state==SETTLING), driven from the state register; no combinational path from data_in.
- update_o defaults to 0 every enabled cycle unless set below.
- en=0: no register changes except update_o<=0; en gaps are not counted as samples and do not break a run.
- STABLE state (en=1):
  - data_in==data_out: hold.
  - data_in!=data_out and STABLE_CYC==1: data_out<=data_in, update_o<=1, stay STABLE.
  - data_in!=data_out and STABLE_CYC>1: cand<=data_in, cnt<=1, go SETTLING.
- SETTLING state (en=1):
  - data_in==cand and cnt==STABLE_CYC-1: data_out<=cand, update_o<=1, cnt<=0, go STABLE.
  - data_in==cand otherwise: cnt<=cnt+1.
  - data_in!=cand and data_in==data_out: abort; cnt<=0, go STABLE; data_out unchanged, no pulse.
  - data_in!=cand and data_in!=data_out: restart; cand<=data_in, cnt<=1, stay SETTLING.
- Latency: if a new value is first sampled at edge E0 and held, data_out changes at edge E0+STABLE_CYC-1; update_o is high in the following cycle.
- Back-to-back changes: a value accepted at edge E may be replaced by a new candidate first sampled at E+1; this gives minimum update_o spacing of STABLE_CYC cycles.
- cnt never exceeds STABLE_CYC-1; no wrap.
- Reset mid-SETTLING discards the candidate; data_out returns to rst_val immediately (async).

Optional Feature:
- Macro IOB_SYNC_STABLE_QUAL_GLITCH_CNT_EN.
- Defined:
  - Adds output glitch_cnt_o, 16 bits, reset 0.
  - Increments by 1 on each abort or restart in SETTLING while en=1.
  - Saturates at 16'hFFFF; no wrap.
  - Adds input glitch_clr (1 bit), synchronous clear; clear wins over a simultaneous increment.
- Undefined: neither port exists; no counter logic is present.

Decomposition:
- Shared package iob_sync_pkg:
  - State encoding constants ST_STABLE=1'b0, ST_SETTLING=1'b1.
  - GLITCH_CNT_W=16.
- Localparam CNT_W=$clog2(STABLE_CYC+1), computed in the module.
- No sub-module; a single FSM+datapath is natural. The saturating glitch counter stays inline under the macro.

Test Plan:
- Reset, STABLE_CYC=3, rst_val=32'hA5A5A5A5, data_in=32'hA5A5A5A5 -> data_out=32'hA5A5A5A5, update_o=0, settling_o=0 for 10 cycles.
- Clean change: data_in 0->32'h12345678 first sampled at E0 and held -> settling_o=1 after E0; data_out=32'h12345678 after E0+2; update_o high exactly one cycle.
- Single-cycle glitch: data_out=0, data_in=32'h0000FF00 for one cycle, then back to 0 -> data_out stays 0, no update_o. With the macro defined, glitch_cnt_o=1.
- Skewed bits: data_in 0->32'h0F then 32'hFF (one cycle each), then held at 32'hFF -> data_out=32'hFF 3 cycles after 32'hFF first sampled; one update_o pulse; 32'h0F never output.
- en gating: change to 32'h5 with en toggling 1,0,1,0,1 -> accepted only after 3 enabled samples; update_o never high while en=0.
- Async reset asserted mid-SETTLING with rst_val=32'h77 -> data_out=32'h77 and settling_o=0 before the next clk edge; no update_o after release.
